// File: rtl/sme_mask_encode.sv
// sme_mask_encode: splits a plaintext word into D boolean shares using D-1 fresh random words
module sme_mask_encode #(
  parameter int D = 3,
  parameter int N = 32
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         rng_req,
  input  logic         rng_ack,
  input  logic [N-1:0] rng_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_shares [D]
);
  localparam int CW = $clog2(D);
  typedef enum logic [1:0] {IDLE, GATHER, OUT} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_share [D];
  logic          w_last, w_accept, w_take, w_done;
  assign w_last   = r_cnt == CW'(D - 2);
  assign w_accept = !flush && r_state == IDLE && in_valid;
  assign w_take   = !flush && r_state == GATHER && rng_ack;
  assign w_done   = r_state == OUT && out_ready;
  // state register
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) r_state <= IDLE;
    else r_state <= w_next;
  // next state and handshake outputs, flush overrides every other event
  always_comb begin
    in_ready  = r_state == IDLE;
    rng_req   = r_state == GATHER;
    out_valid = r_state == OUT;
    w_next    = r_state;
    if (flush) w_next = IDLE;
    else if (w_accept) w_next = GATHER;
    else if (w_take && w_last) w_next = OUT;
    else if (w_done) w_next = IDLE;
  end
  // accumulator, counter and share registers; the plaintext only lives in r_acc
  always_ff @(posedge g_clk or negedge g_resetn)
    if (!g_resetn) begin
      r_acc <= '0;
      r_cnt <= '0;
      for (int k = 0; k < D; k++) r_share[k] <= '0;
    end else if (flush || w_done) begin
      r_acc <= '0;
      r_cnt <= '0;
      for (int k = 0; k < D; k++) r_share[k] <= '0;
    end else if (w_accept) begin
      r_acc <= in_data;
      r_cnt <= '0;
    end else if (w_take) begin
      r_acc <= r_acc ^ rng_data;
      r_cnt <= r_cnt + CW'(1);
      for (int k = 1; k < D; k++)
        if (k == int'(r_cnt) + 1) r_share[k] <= rng_data;
      if (w_last) r_share[0] <= r_acc ^ rng_data;
    end
  // shares are only visible while the set is being offered
  for (genvar g = 0; g < D; g++) begin : g_out
    assign out_shares[g] = out_valid ? r_share[g] : '0;
  end
endmodule
